// File: rtl/vga_fetch_sched_if.sv
// Burst read handshake between the fetch scheduler (master) and the memory read engine (slave).
interface vga_fetch_sched_if;
  logic        req;
  logic [31:0] req_addr;
  logic        ack;
  logic        burst_done;

  modport master (output req, output req_addr, input ack, input burst_done);
  modport slave  (input req, input req_addr, output ack, output burst_done);
endinterface

// File: rtl/vga_fetch_sched.sv
// Frame-buffer fetch scheduler: one burst read at a time, frame start on VS falling edge,
// throttled by pixel FIFO fill level, with frame-done pulse and sticky late-frame flag.
//
// state     | meaning
// IDLE      | disabled, nothing in flight
// WAIT_VS   | armed, waiting for VS falling edge
// START     | latch frame base, clear burst count
// CHECK     | wait for room for one burst in the pixel FIFO
// REQ       | request held until accepted
// WAIT_DATA | burst accepted, waiting for its data to land in the FIFO
module vga_fetch_sched #(
  parameter int HDISP      = 800,
  parameter int VDISP      = 480,
  parameter int BURST      = 16,
  parameter int FIFO_DEPTH = 256,
  parameter int BPP_BYTES  = 4
) (
  input  logic                            pixel_clk,
  input  logic                            pixel_rst,
  input  logic                            enable,
  input  logic [31:0]                     frame_base,
  input  logic                            vs,
  input  logic [$clog2(FIFO_DEPTH+1)-1:0] fifo_level,
  vga_fetch_sched_if.master               rd,
  output logic                            frame_done,
  output logic                            frame_late
);

  localparam int TOTAL = HDISP * VDISP / BURST;
  localparam int BW    = $clog2(TOTAL + 1);
  localparam int LW    = $clog2(FIFO_DEPTH + 1);
  localparam logic [31:0]   STEP   = 32'(BURST * BPP_BYTES);
  localparam logic [LW-1:0] THRESH = LW'(FIFO_DEPTH - BURST);
  localparam logic [BW-1:0] LAST   = BW'(TOTAL);

  if ((HDISP * VDISP) % BURST != 0) begin : g_bad_burst
    $error("vga_fetch_sched: HDISP*VDISP must be a multiple of BURST");
  end
  if (FIFO_DEPTH < BURST) begin : g_bad_depth
    $error("vga_fetch_sched: FIFO_DEPTH must be at least BURST");
  end

  typedef enum logic [2:0] {IDLE, WAIT_VS, START, CHECK, REQ, WAIT_DATA} state_t;

  state_t        state, state_nxt;
  logic          vs_q;
  logic          vs_fall;
  logic          pend, pend_nxt;
  logic [BW-1:0] bcnt, bcnt_nxt;
  logic          req_r, req_nxt;
  logic [31:0]   addr_r, addr_nxt;
  logic          done_nxt;
  logic          late_nxt;
  logic          last_done;

  assign vs_fall     = vs_q & ~vs;
  assign rd.req      = req_r;
  assign rd.req_addr = addr_r;

  always_ff @(posedge pixel_clk) begin
    if (pixel_rst) begin
      state      <= IDLE;
      vs_q       <= 1'b1;
      pend       <= 1'b0;
      bcnt       <= '0;
      req_r      <= 1'b0;
      addr_r     <= '0;
      frame_done <= 1'b0;
      frame_late <= 1'b0;
    end else begin
      state      <= state_nxt;
      vs_q       <= vs;
      pend       <= pend_nxt;
      bcnt       <= bcnt_nxt;
      req_r      <= req_nxt;
      addr_r     <= addr_nxt;
      frame_done <= done_nxt;
      frame_late <= late_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    pend_nxt  = pend;
    bcnt_nxt  = bcnt;
    req_nxt   = req_r;
    addr_nxt  = addr_r;
    done_nxt  = 1'b0;
    late_nxt  = frame_late;
    last_done = (state == WAIT_DATA) && rd.burst_done && (bcnt == LAST);

    case (state)
      IDLE: begin
        if (enable) state_nxt = WAIT_VS;
      end
      WAIT_VS: begin
        if (!enable)     state_nxt = IDLE;
        else if (vs_fall) state_nxt = START;
      end
      START: begin
        addr_nxt  = frame_base;
        bcnt_nxt  = '0;
        pend_nxt  = 1'b0;
        state_nxt = CHECK;
      end
      CHECK: begin
        if (fifo_level <= THRESH) begin
          req_nxt   = 1'b1;
          state_nxt = REQ;
        end
      end
      REQ: begin
        if (rd.ack) begin
          req_nxt   = 1'b0;
          addr_nxt  = addr_r + STEP;
          bcnt_nxt  = bcnt + 1'b1;
          state_nxt = WAIT_DATA;
        end
      end
      WAIT_DATA: begin
        if (rd.burst_done) begin
          if (bcnt < LAST) begin
            state_nxt = CHECK;
          end else begin
            done_nxt = 1'b1;
            // disabling mid-frame wins over a pending restart
            if (!enable) begin
              pend_nxt  = 1'b0;
              state_nxt = IDLE;
            end else if (pend || vs_fall) begin
              state_nxt = START;
            end else begin
              state_nxt = WAIT_VS;
            end
          end
        end
      end
      default: state_nxt = IDLE;
    endcase

    // a VS edge landing on the final burst_done starts the next frame directly, so it is not late
    if ((state inside {START, CHECK, REQ, WAIT_DATA}) && vs_fall && !last_done) begin
      pend_nxt = 1'b1;
      late_nxt = 1'b1;
    end
  end

endmodule

// File: tb/tb_vga_fetch_sched.sv
// Scoreboard bench for vga_fetch_sched: expected burst addresses are queued per frame and
// popped as the memory responder accepts each request.
module tb_vga_fetch_sched;
  localparam int HDISP      = 32;
  localparam int VDISP      = 4;
  localparam int BURST      = 16;
  localparam int FIFO_DEPTH = 64;
  localparam int BPP_BYTES  = 4;
  localparam int TOTAL      = 8;
  localparam int LW         = $clog2(FIFO_DEPTH + 1);

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          enable = 1'b0;
  logic [31:0]   frame_base = '0;
  logic          vs = 1'b1;
  logic [LW-1:0] fifo_level = '0;
  logic          frame_done;
  logic          frame_late;

  vga_fetch_sched_if bus();

  vga_fetch_sched #(
    .HDISP(HDISP), .VDISP(VDISP), .BURST(BURST), .FIFO_DEPTH(FIFO_DEPTH), .BPP_BYTES(BPP_BYTES)
  ) dut (
    .pixel_clk (clk),
    .pixel_rst (rst),
    .enable    (enable),
    .frame_base(frame_base),
    .vs        (vs),
    .fifo_level(fifo_level),
    .rd        (bus.master),
    .frame_done(frame_done),
    .frame_late(frame_late)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end
  endtask

  logic [31:0] exp_q[$];

  task automatic push_frame(input logic [31:0] base);
    for (int i = 0; i < TOTAL; i++) exp_q.push_back(base + 32'(i * BURST * BPP_BYTES));
  endtask

  int ack_delay = 0;
  bit resp_en   = 1'b1;
  int xfers     = 0;
  int bdones    = 0;
  int fd_cnt    = 0;
  int req_rises = 0;

  // memory read engine model
  initial begin
    logic [31:0] a;
    bus.ack = 1'b0;
    bus.burst_done = 1'b0;
    forever begin
      @(negedge clk);
      if (resp_en && !rst && bus.req) begin
        a = bus.req_addr;
        for (int i = 0; i < ack_delay; i++) begin
          @(negedge clk);
          check("req_hold", 32'(bus.req), 32'd1);
          check("addr_hold", bus.req_addr, a);
        end
        if (exp_q.size() == 0) check("sb_underflow", 32'(exp_q.size()), 32'd1);
        else check("req_addr", a, exp_q.pop_front());
        bus.ack = 1'b1;
        xfers++;
        @(negedge clk);
        bus.ack = 1'b0;
        @(negedge clk);
        bus.burst_done = 1'b1;
        @(negedge clk);
        bus.burst_done = 1'b0;
        bdones++;
      end
    end
  end

  initial begin
    logic req_prev;
    int   xfer_mark;
    req_prev  = 1'b0;
    xfer_mark = 0;
    forever begin
      @(negedge clk);
      if (bus.req && !req_prev) req_rises++;
      req_prev = bus.req;
      if (frame_done) begin
        fd_cnt++;
        check("frame_bursts", 32'(xfers - xfer_mark), 32'(TOTAL));
        xfer_mark = xfers;
      end
    end
  end

  task automatic vs_pulse();
    @(negedge clk);
    vs = 1'b0;
    repeat (2) @(negedge clk);
    vs = 1'b1;
  endtask

  task automatic wait_fd(input int target, input int budget);
    int n;
    n = 0;
    while (fd_cnt < target && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("frame_done_timeout", 32'(fd_cnt >= target), 32'd1);
  endtask

  task automatic wait_bdones(input int target, input int budget);
    int n;
    n = 0;
    while (bdones < target && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("burst_done_timeout", 32'(bdones >= target), 32'd1);
  endtask

  initial begin
    int rr;
    int fd0;
    int n;

    repeat (3) @(negedge clk);
    check("rst_req", 32'(bus.req), 32'd0);
    check("rst_addr", bus.req_addr, 32'd0);
    check("rst_frame_done", 32'(frame_done), 32'd0);
    check("rst_frame_late", 32'(frame_late), 32'd0);
    rst = 1'b0;

    // 1: basic frame
    enable = 1'b1;
    frame_base = 32'h1000;
    push_frame(32'h1000);
    vs_pulse();
    wait_fd(1, 400);
    repeat (3) @(negedge clk);
    check("t1_fd_cnt", 32'(fd_cnt), 32'd1);
    check("t1_xfers", 32'(xfers), 32'(TOTAL));
    check("t1_req_idle", 32'(bus.req), 32'd0);
    check("t1_late", 32'(frame_late), 32'd0);

    // 2: FIFO throttle at the threshold boundary
    fifo_level = LW'(49);
    frame_base = 32'h3000;
    push_frame(32'h3000);
    rr = req_rises;
    vs_pulse();
    repeat (10) @(negedge clk);
    check("t2_req_blocked", 32'(bus.req), 32'd0);
    check("t2_no_rise", 32'(req_rises), 32'(rr));
    fifo_level = LW'(48);
    @(negedge clk);
    check("t2_req_rise", 32'(bus.req), 32'd1);
    wait_fd(2, 400);
    fifo_level = '0;

    // 3: slow ack
    ack_delay = 5;
    frame_base = 32'h4000;
    push_frame(32'h4000);
    vs_pulse();
    wait_fd(3, 600);
    ack_delay = 0;
    check("t3_xfers", 32'(xfers), 32'(3 * TOTAL));

    // 4: VS arrives mid-frame, next frame restarts without another VS
    frame_base = 32'h2000;
    push_frame(32'h2000);
    vs_pulse();
    wait_bdones(bdones + 3, 200);
    check("t4_late_before", 32'(frame_late), 32'd0);
    vs_pulse();
    frame_base = 32'h8000;
    push_frame(32'h8000);
    check("t4_late_set", 32'(frame_late), 32'd1);
    wait_fd(5, 800);
    check("t4_fd_cnt", 32'(fd_cnt), 32'd5);
    check("t4_sb_empty", 32'(exp_q.size()), 32'd0);

    // 5: disable mid-frame, addresses wrap past 2^32
    frame_base = 32'hFFFF_FF80;
    push_frame(32'hFFFF_FF80);
    vs_pulse();
    wait_bdones(bdones + 2, 200);
    enable = 1'b0;
    wait_fd(6, 400);
    repeat (3) @(negedge clk);
    rr  = req_rises;
    fd0 = fd_cnt;
    vs_pulse();
    repeat (20) @(negedge clk);
    check("t5_no_req", 32'(req_rises), 32'(rr));
    check("t5_no_fd", 32'(fd_cnt), 32'(fd0));
    check("t5_late_sticky", 32'(frame_late), 32'd1);

    // 6: reset while a request is outstanding
    resp_en = 1'b0;
    enable  = 1'b1;
    frame_base = 32'h7000;
    vs_pulse();
    n = 0;
    while (!bus.req && n < 30) begin
      @(negedge clk);
      n++;
    end
    check("t6_req_up", 32'(bus.req), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    check("t6_rst_req", 32'(bus.req), 32'd0);
    check("t6_rst_addr", bus.req_addr, 32'd0);
    check("t6_rst_late", 32'(frame_late), 32'd0);
    enable = 1'b0;
    rst = 1'b0;
    rr = req_rises;
    repeat (10) @(negedge clk);
    enable = 1'b1;
    repeat (10) @(negedge clk);
    check("t6_no_req", 32'(req_rises), 32'(rr));
    resp_en = 1'b1;
    frame_base = 32'h5000;
    push_frame(32'h5000);
    vs_pulse();
    wait_fd(7, 400);
    check("t6_sb_empty", 32'(exp_q.size()), 32'd0);
    check("t6_late_clear", 32'(frame_late), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end
endmodule
